// File: rtl/wb_master_pkg.sv
// Shared types for the Wishbone classic single-access initiator.
package wb_master_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RELEASE = 2'd2
  } state_t;

endpackage

// File: rtl/wb_master.sv
// Wishbone classic single-access initiator with a four-phase STB/ACK handshake.
// Optional ACCESS timeout abort is enabled by defining WB_MASTER_TIMEOUT_EN.
module wb_master
  import wb_master_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_i,
  input  logic                    we_i,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic [DATA_WIDTH-1:0]   data_i,
  input  logic [DATA_WIDTH/8-1:0] sel_i,
  output logic                    ready_o,
  output logic                    done_o,
  output logic                    err_o,
  output logic [DATA_WIDTH-1:0]   data_o,
  output logic [ADDR_WIDTH-1:0]   ADR_O,
  output logic [DATA_WIDTH-1:0]   DAT_O,
  input  logic [DATA_WIDTH-1:0]   DAT_I,
  output logic                    WE_O,
  output logic [DATA_WIDTH/8-1:0] SEL_O,
  output logic                    STB_O,
  output logic                    CYC_O,
  input  logic                    ACK_I
);

  localparam int SEL_W = DATA_WIDTH / 8;

  state_t                r_state, w_state;
  logic                  r_ready, w_ready;
  logic                  r_done,  w_done;
  logic                  r_err,   w_err;
  logic                  r_stb,   w_stb;
  logic                  r_we,    w_we;
  logic [DATA_WIDTH-1:0] r_data,  w_data;
  logic [ADDR_WIDTH-1:0] r_adr,   w_adr;
  logic [DATA_WIDTH-1:0] r_dat,   w_dat;
  logic [SEL_W-1:0]      r_sel,   w_sel;

`ifdef WB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_cnt, w_cnt;
`endif

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    w_state = r_state;
    w_ready = r_ready;
    w_done  = 1'b0;
    w_err   = r_err;
    w_stb   = r_stb;
    w_we    = r_we;
    w_data  = r_data;
    w_adr   = r_adr;
    w_dat   = r_dat;
    w_sel   = r_sel;
`ifdef WB_MASTER_TIMEOUT_EN
    w_cnt   = r_cnt;
`endif
    case (r_state)
      IDLE: begin
        if (req_i) begin
          w_adr   = addr_i;
          w_sel   = sel_i;
          w_we    = we_i;
          w_stb   = 1'b1;
          w_ready = 1'b0;
          w_state = ACCESS;
          // DAT_O keeps its last write value across reads
          if (we_i) begin
            w_dat = data_i;
          end else begin
            w_dat = r_dat;
          end
`ifdef WB_MASTER_TIMEOUT_EN
          w_cnt = {CNT_W{1'b0}};
`endif
        end else begin
          w_ready = 1'b1;
        end
      end
      ACCESS: begin
        // A stale ACK on entry counts: the slave only drops it once STB falls
        if (ACK_I) begin
          w_stb   = 1'b0;
          w_done  = 1'b1;
          w_err   = 1'b0;
          w_state = RELEASE;
          if (!r_we) begin
            w_data = DAT_I;
          end else begin
            w_data = r_data;
          end
        end
`ifdef WB_MASTER_TIMEOUT_EN
        else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          w_stb   = 1'b0;
          w_done  = 1'b1;
          w_err   = 1'b1;
          w_state = RELEASE;
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
`else
        else begin
          w_state = ACCESS;
        end
`endif
      end
      RELEASE: begin
        if (!ACK_I) begin
          w_state = IDLE;
          w_ready = 1'b1;
          w_we    = 1'b0;
        end else begin
          w_state = RELEASE;
        end
      end
      default: begin
        w_state = IDLE;
        w_ready = 1'b1;
        w_stb   = 1'b0;
        w_we    = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any access in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_stb   <= 1'b0;
      r_we    <= 1'b0;
      r_data  <= {DATA_WIDTH{1'b0}};
      r_adr   <= {ADDR_WIDTH{1'b0}};
      r_dat   <= {DATA_WIDTH{1'b0}};
      r_sel   <= {SEL_W{1'b0}};
`ifdef WB_MASTER_TIMEOUT_EN
      r_cnt   <= {CNT_W{1'b0}};
`endif
    end else begin
      r_state <= w_state;
      r_ready <= w_ready;
      r_done  <= w_done;
      r_err   <= w_err;
      r_stb   <= w_stb;
      r_we    <= w_we;
      r_data  <= w_data;
      r_adr   <= w_adr;
      r_dat   <= w_dat;
      r_sel   <= w_sel;
`ifdef WB_MASTER_TIMEOUT_EN
      r_cnt   <= w_cnt;
`endif
    end
  end

  assign ready_o = r_ready;
  assign done_o  = r_done;
  assign err_o   = r_err;
  assign data_o  = r_data;
  assign ADR_O   = r_adr;
  assign DAT_O   = r_dat;
  assign WE_O    = r_we;
  assign SEL_O   = r_sel;
  assign STB_O   = r_stb;
  assign CYC_O   = r_stb;

endmodule

// File: tb/tb_wb_master.sv
// Directed self-checking bench for wb_master; the timeout scenario follows WB_MASTER_TIMEOUT_EN.
`timescale 1ns/1ps
module tb_wb_master;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_i = 1'b0;
  logic        we_i = 1'b0;
  logic [31:0] addr_i = 32'h0;
  logic [31:0] data_i = 32'h0;
  logic [3:0]  sel_i = 4'h0;
  logic        ready_o, done_o, err_o, WE_O, STB_O, CYC_O;
  logic [31:0] data_o, ADR_O, DAT_O;
  logic [31:0] DAT_I = 32'h0;
  logic [3:0]  SEL_O;
  logic        ACK_I;
  logic        ack_drv = 1'b0;
  logic        auto_ack = 1'b0;
  logic        ack_d = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;

  wb_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .data_i(data_i), .sel_i(sel_i), .ready_o(ready_o), .done_o(done_o), .err_o(err_o),
    .data_o(data_o), .ADR_O(ADR_O), .DAT_O(DAT_O), .DAT_I(DAT_I), .WE_O(WE_O),
    .SEL_O(SEL_O), .STB_O(STB_O), .CYC_O(CYC_O), .ACK_I(ACK_I)
  );

  always #5 clk_i = ~clk_i;

  // Zero-wait slave: ACK rises with STB and falls one cycle after STB drops
  always @(posedge clk_i) ack_d <= STB_O;
  assign ACK_I = auto_ack ? (STB_O | ack_d) : ack_drv;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    tick(); tick();
    n_checks++;
    if ({ready_o, done_o, err_o, STB_O, CYC_O, WE_O} !== 6'b100000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 100000", {ready_o, done_o, err_o, STB_O, CYC_O, WE_O});
    end
    n_checks++;
    if ({ADR_O, DAT_O, SEL_O, data_o} !== 100'h0) begin
      n_fail++; $display("FAIL reset_data: got adr=%h dat=%h sel=%h data=%h expected all 0", ADR_O, DAT_O, SEL_O, data_o);
    end
    rst_i = 1'b0;
    ack_drv = 1'b1;
    tick(); tick();
    n_checks++;
    if ({ready_o, STB_O, done_o} !== 3'b100) begin
      n_fail++; $display("FAIL idle_ack_ignored: got %b expected 100", {ready_o, STB_O, done_o});
    end
    ack_drv = 1'b0;
  endtask

  task automatic test_read();
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h0000_0010; sel_i = 4'hF; data_i = 32'hAAAA_AAAA;
    tick();
    n_checks++;
    if ({STB_O, CYC_O, ready_o, WE_O} !== 4'b1100) begin
      n_fail++; $display("FAIL read_start: got %b expected 1100", {STB_O, CYC_O, ready_o, WE_O});
    end
    n_checks++;
    if ({ADR_O, DAT_O, SEL_O} !== {32'h10, 32'h0, 4'hF}) begin
      n_fail++; $display("FAIL read_bus: got adr=%h dat=%h sel=%h expected 10 0 f", ADR_O, DAT_O, SEL_O);
    end
    req_i = 1'b0;
    tick(); tick();
    ack_drv = 1'b1; DAT_I = 32'hDEAD_BEEF;
    tick();
    n_checks++;
    if ({STB_O, CYC_O, done_o, err_o, ready_o} !== 5'b00100) begin
      n_fail++; $display("FAIL read_done: got %b expected 00100", {STB_O, CYC_O, done_o, err_o, ready_o});
    end
    n_checks++;
    if (data_o !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL read_data: got %h expected deadbeef", data_o);
    end
    ack_drv = 1'b0;
    tick();
    n_checks++;
    if ({ready_o, done_o} !== 2'b10) begin
      n_fail++; $display("FAIL read_ready: got %b expected 10", {ready_o, done_o});
    end
  endtask

  task automatic test_write();
    req_i = 1'b1; we_i = 1'b1; addr_i = 32'h20; data_i = 32'h1234_5678; sel_i = 4'h3;
    tick();
    req_i = 1'b0; data_i = 32'hFFFF_0000; addr_i = 32'h99; sel_i = 4'hC;
    tick();
    n_checks++;
    if ({STB_O, WE_O, ADR_O, DAT_O, SEL_O} !== {1'b1, 1'b1, 32'h20, 32'h1234_5678, 4'h3}) begin
      n_fail++; $display("FAIL write_bus: got stb=%b we=%b adr=%h dat=%h sel=%h", STB_O, WE_O, ADR_O, DAT_O, SEL_O);
    end
    ack_drv = 1'b1; DAT_I = 32'h5555_5555;
    tick();
    n_checks++;
    if ({done_o, err_o, data_o} !== {1'b1, 1'b0, 32'hDEAD_BEEF}) begin
      n_fail++; $display("FAIL write_done: got done=%b err=%b data=%h expected 1 0 deadbeef", done_o, err_o, data_o);
    end
    ack_drv = 1'b0;
    tick();
    n_checks++;
    if ({ready_o, WE_O, STB_O} !== 3'b100) begin
      n_fail++; $display("FAIL write_release: got %b expected 100", {ready_o, WE_O, STB_O});
    end
  endtask

  task automatic test_four_phase();
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h30; sel_i = 4'hF;
    tick();
    req_i = 1'b0; ack_drv = 1'b1; DAT_I = 32'hCAFE_F00D;
    tick();
    n_checks++;
    if ({done_o, STB_O} !== 2'b10) begin
      n_fail++; $display("FAIL fp_done: got %b expected 10", {done_o, STB_O});
    end
    req_i = 1'b1; we_i = 1'b1; addr_i = 32'h44;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if ({ready_o, STB_O, done_o} !== 3'b000) begin
        n_fail++; $display("FAIL fp_hold%0d: got %b expected 000", i, {ready_o, STB_O, done_o});
      end
    end
    ack_drv = 1'b0; req_i = 1'b0;
    tick();
    n_checks++;
    if ({ready_o, STB_O, WE_O, ADR_O, data_o} !== {3'b100, 32'h30, 32'hCAFE_F00D}) begin
      n_fail++; $display("FAIL fp_release: got rdy=%b stb=%b we=%b adr=%h data=%h", ready_o, STB_O, WE_O, ADR_O, data_o);
    end
  endtask

  task automatic test_back_to_back();
    int  first = -1;
    int  second = -1;
    int  dones = 0;
    int  overlap = 0;
    logic prev_stb = 1'b0;
    auto_ack = 1'b1; DAT_I = 32'h0BAD_CAFE;
    req_i = 1'b1; we_i = 1'b1; addr_i = 32'h40; data_i = 32'hA5A5_A5A5; sel_i = 4'hF;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (STB_O && !prev_stb) begin
        if (first < 0) begin
          first = c; we_i = 1'b0; addr_i = 32'h44;
        end else begin
          second = c; req_i = 1'b0;
        end
      end
      prev_stb = STB_O;
      if (done_o && ready_o) overlap++;
      if (done_o) dones++;
    end
    auto_ack = 1'b0;
    n_checks++;
    if (second - first !== 4) begin
      n_fail++; $display("FAIL b2b_spacing: got first=%0d second=%0d expected spacing 4", first, second);
    end
    n_checks++;
    if ({overlap, dones} !== {32'd0, 32'd2}) begin
      n_fail++; $display("FAIL b2b_done: got overlap=%0d dones=%0d expected 0 2", overlap, dones);
    end
    n_checks++;
    if ({data_o, DAT_O, ADR_O} !== {32'h0BAD_CAFE, 32'hA5A5_A5A5, 32'h44}) begin
      n_fail++; $display("FAIL b2b_data: got data=%h dat=%h adr=%h expected 0badcafe a5a5a5a5 44", data_o, DAT_O, ADR_O);
    end
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h50; sel_i = 4'hF;
    tick();
    req_i = 1'b0;
    rst_i = 1'b1; ack_drv = 1'b1;
    #1;
    n_checks++;
    if ({STB_O, CYC_O, ready_o, done_o} !== 4'b0010) begin
      n_fail++; $display("FAIL rst_mid_async: got %b expected 0010", {STB_O, CYC_O, ready_o, done_o});
    end
    tick();
    rst_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done_o) dones++;
    end
    ack_drv = 1'b0;
    tick();
    n_checks++;
    if ({dones, ready_o, STB_O, data_o, ADR_O} !== {32'd0, 2'b10, 32'h0, 32'h0}) begin
      n_fail++; $display("FAIL rst_mid_after: got dones=%0d rdy=%b stb=%b data=%h adr=%h", dones, ready_o, STB_O, data_o, ADR_O);
    end
  endtask

`ifdef WB_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    int early = 0;
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h60; sel_i = 4'hF; DAT_I = 32'h1111_2222;
    for (int i = 1; i <= 8; i++) begin
      tick();
      req_i = 1'b0;
      if (!STB_O || done_o) early++;
    end
    tick();
    n_checks++;
    if ({early, STB_O, done_o, err_o, data_o} !== {32'd0, 3'b011, 32'h0}) begin
      n_fail++; $display("FAIL to_abort: got early=%0d stb=%b done=%b err=%b data=%h", early, STB_O, done_o, err_o, data_o);
    end
    tick();
    n_checks++;
    if ({ready_o, done_o} !== 2'b10) begin
      n_fail++; $display("FAIL to_ready: got %b expected 10", {ready_o, done_o});
    end
    req_i = 1'b1; DAT_I = 32'h7777_0008;
    for (int i = 1; i <= 8; i++) begin
      tick();
      req_i = 1'b0;
    end
    ack_drv = 1'b1;
    tick();
    n_checks++;
    if ({STB_O, done_o, err_o, data_o} !== {3'b010, 32'h7777_0008}) begin
      n_fail++; $display("FAIL to_ack_wins: got stb=%b done=%b err=%b data=%h", STB_O, done_o, err_o, data_o);
    end
    ack_drv = 1'b0;
    tick();
  endtask
`else
  task automatic test_timeout();
    int dropped = 0;
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h60; sel_i = 4'hF; DAT_I = 32'h1111_2222;
    for (int i = 1; i <= 20; i++) begin
      tick();
      req_i = 1'b0;
      if (!STB_O || done_o || err_o) dropped++;
    end
    n_checks++;
    if (dropped !== 0) begin
      n_fail++; $display("FAIL no_timeout_wait: got %0d early exits expected 0", dropped);
    end
    ack_drv = 1'b1;
    tick();
    n_checks++;
    if ({STB_O, done_o, err_o, data_o} !== {3'b010, 32'h1111_2222}) begin
      n_fail++; $display("FAIL no_timeout_done: got stb=%b done=%b err=%b data=%h", STB_O, done_o, err_o, data_o);
    end
    ack_drv = 1'b0;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_read();
    test_write();
    test_four_phase();
    test_back_to_back();
    test_reset_mid();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
